// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals.
// slave = arbiter view, master = requester/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_done, if_rdata,
    input  d_req, d_we, d_addr, d_be, d_wdata,
    output d_done, d_rdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_done, if_rdata,
    output d_req, d_we, d_addr, d_be, d_wdata,
    input  d_done, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port memory with req/ack handshake.
// Optional perf counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_if_wait_cnt
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC,
    RESP
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;
  logic [3:0]        streak_q;

  logic              grant_i;
  logic              grant_d;
  logic [3:0]        streak_inc;
  logic [ADDR_W-1:0] if_addr_al;

  // Grant decision: data has priority unless fetch has waited too long.
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    if (state_q == IDLE) begin
      grant_i = bus.if_req &&
                (!bus.d_req || streak_q == LIMIT);
      grant_d = bus.d_req && !grant_i;
    end
    streak_inc = (streak_q == 4'hF) ? 4'hF
                                    : streak_q + 4'd1;
    if_addr_al = bus.if_addr & ~ADDR_W'(3);
  end

  // Arbitration FSM with registered memory-side and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      streak_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if_done_q <= 1'b0;
          d_done_q  <= 1'b0;
          unique case (1'b1)
            grant_i: begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= if_addr_al;
              mem_be_q   <= '1;
              streak_q   <= '0;
              state_q    <= I_ACC;
            end
            grant_d: begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              mem_be_q    <= bus.d_be;
              mem_wdata_q <= bus.d_wdata;
              streak_q    <= bus.if_req ? streak_inc : 4'd0;
              state_q     <= D_ACC;
            end
            default: ;
          endcase
        end
        I_ACC: begin
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            if_rdata_q <= bus.mem_rdata;
            if_done_q  <= 1'b1;
            state_q    <= RESP;
          end
        end
        D_ACC: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
            d_done_q  <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if_done_q <= 1'b0;
          d_done_q  <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conf_cnt_q;
  logic [31:0] wait_cnt_q;
  logic        if_waiting;

  // Fetch is waiting unless granted now or its own access is in flight.
  assign if_waiting = bus.if_req && !grant_i &&
                      state_q != I_ACC &&
                      !(state_q == RESP && if_done_q);

  // Wrapping conflict and fetch-wait counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      conf_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && bus.if_req && bus.d_req)
        conf_cnt_q <= conf_cnt_q + 32'd1;
      if (if_waiting)
        wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_conflict_cnt = conf_cnt_q;
  assign perf_if_wait_cnt  = wait_cnt_q;
`endif

endmodule
